inst_prefetch: RTL

Bus-side writer for the 16-byte instruction queue. Starting at a PC given by a redirect, it fetches sequential opcode/operand bytes over a single-outstanding memory read handshake and pushes them into a ring buffer. It presents the three oldest bytes to the decoder, which consumes 0–3 bytes per cycle. It sits between the memory port and the prime decoder, and it flushes and refetches whenever branch or reset-vector logic redirects the PC.

---
 rtl/v6502_pkg.sv | 19 +
 rtl/inst_prefetch_if.sv | 34 +++
 rtl/byte_ring.sv | 47 ++++
 rtl/inst_prefetch.sv | 121 ++++++++++++
 4 files changed

// File: rtl/v6502_pkg.sv
// Shared definitions for the v6502 front end: prefetch FSM states, address width, queue depth.
package v6502_pkg;

  localparam int V6502_ADDR_W  = 16;
  localparam int V6502_Q_DEPTH = 16;

  typedef enum logic [1:0] {
    STOP = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DROP = 2'd3
  } pf_state_t;

  // Decoder may ask for more bytes than are queued; clip to what is actually there.
  function automatic logic [1:0] pf_clip_consume(input logic [1:0] len, input int unsigned avail);
    return (avail < 32'(len)) ? avail[1:0] : len;
  endfunction

endpackage

// File: rtl/inst_prefetch_if.sv
// Bundle of memory-port, redirect and decoder-side signals of the instruction prefetcher.
interface inst_prefetch_if
  import v6502_pkg::*;
#(
  parameter int DEPTH  = V6502_Q_DEPTH,
  parameter int ADDR_W = V6502_ADDR_W
) ();

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [7:0]        mem_rdata;
  logic [1:0]        consume_len;
  logic [7:0]        q_byte0;
  logic [7:0]        q_byte1;
  logic [7:0]        q_byte2;
  logic [CNT_W-1:0]  q_count;
  logic [ADDR_W-1:0] q_pc;

  modport master (
    input  redirect_valid, redirect_pc, mem_ack, mem_rdata, consume_len,
    output mem_req, mem_addr, q_byte0, q_byte1, q_byte2, q_count, q_pc
  );

  modport slave (
    output redirect_valid, redirect_pc, mem_ack, mem_rdata, consume_len,
    input  mem_req, mem_addr, q_byte0, q_byte1, q_byte2, q_count, q_pc
  );

endinterface

// File: rtl/byte_ring.sv
// DEPTH x 8 byte ring: one write port at tail, three read ports at head..head+2, zero-masked by count.
module byte_ring #(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic [7:0]               i_wdata,
  input  logic [1:0]               i_pop,
  input  logic [$clog2(DEPTH):0]   i_count,
  output logic [2:0][7:0]          o_bytes
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [7:0]       r_mem [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [PTR_W-1:0] w_rd_idx [3];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head <= '0;
      r_tail <= '0;
    end else if (i_flush) begin
      r_head <= r_tail;
    end else begin
      r_head <= r_head + PTR_W'(i_pop);
      if (i_push)
        r_tail <= r_tail + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_push && !i_flush)
      r_mem[r_tail] <= i_wdata;
  end

  // Pointer arithmetic is PTR_W bits wide, so the +gi offset wraps mod DEPTH.
  for (genvar gi = 0; gi < 3; gi++) begin : g_rd
    assign w_rd_idx[gi] = r_head + PTR_W'(gi);
    assign o_bytes[gi]  = (i_count > CNT_W'(gi)) ? r_mem[w_rd_idx[gi]] : 8'h00;
  end

endmodule

// File: rtl/inst_prefetch.sv
// Instruction prefetcher: sequential byte fetch into a ring queue, flush/refetch on redirect.
// Optional macro INST_PREFETCH_FLUSH_CNT_EN adds the saturating flush_bytes counter output.
module inst_prefetch
  import v6502_pkg::*;
#(
  parameter int DEPTH  = V6502_Q_DEPTH,
  parameter int ADDR_W = V6502_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  inst_prefetch_if.master   bus
`ifdef INST_PREFETCH_FLUSH_CNT_EN
  ,
  output logic [15:0]       flush_bytes
`endif
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  pf_state_t         r_state, w_state_next;
  logic [ADDR_W-1:0] r_fetch_pc, w_fetch_pc_next;
  logic [ADDR_W-1:0] r_mem_addr, w_mem_addr_next;
  logic [ADDR_W-1:0] r_q_pc, w_q_pc_next;
  logic [CNT_W-1:0]  r_count, w_count_next;
  logic              w_ack;
  logic              w_push;
  logic [1:0]        w_consume;
  logic [2:0][7:0]   w_bytes;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= STOP;
      r_fetch_pc <= '0;
      r_mem_addr <= '0;
      r_q_pc     <= '0;
      r_count    <= '0;
    end else begin
      r_state    <= w_state_next;
      r_fetch_pc <= w_fetch_pc_next;
      r_mem_addr <= w_mem_addr_next;
      r_q_pc     <= w_q_pc_next;
      r_count    <= w_count_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_ack           = bus.mem_ack && (r_state == REQ || r_state == DROP);
    w_push          = bus.mem_ack && (r_state == REQ) && !bus.redirect_valid;
    w_consume       = bus.redirect_valid ? 2'd0 : pf_clip_consume(bus.consume_len, int'(r_count));
    w_count_next    = r_count + CNT_W'(w_push) - CNT_W'(w_consume);
    w_fetch_pc_next = w_push ? r_fetch_pc + 1'b1 : r_fetch_pc;
    w_q_pc_next     = r_q_pc + ADDR_W'(w_consume);

    if (bus.redirect_valid) begin
      w_count_next    = '0;
      w_fetch_pc_next = bus.redirect_pc;
      w_q_pc_next     = bus.redirect_pc;
      // An unacked request must still complete on the bus before refetching.
      if ((r_state == REQ && !bus.mem_ack) || r_state == DROP)
        w_state_next = DROP;
      else
        w_state_next = REQ;
    end else begin
      case (r_state)
        STOP:       w_state_next = STOP;
        REQ, WAIT:  w_state_next = (w_count_next < CNT_W'(DEPTH)) ? REQ : WAIT;
        DROP:       w_state_next = bus.mem_ack ? REQ : DROP;
        default:    w_state_next = STOP;
      endcase
    end

    // DROP keeps presenting the old address until its ack retires it.
    w_mem_addr_next = (w_state_next == REQ) ? w_fetch_pc_next : r_mem_addr;
  end

  byte_ring #(
    .DEPTH (DEPTH)
  ) u_ring (
    .clk     (clk),
    .rst     (rst),
    .i_flush (bus.redirect_valid),
    .i_push  (w_push),
    .i_wdata (bus.mem_rdata),
    .i_pop   (w_consume),
    .i_count (r_count),
    .o_bytes (w_bytes)
  );

  assign bus.mem_req  = (r_state == REQ) || (r_state == DROP);
  assign bus.mem_addr = r_mem_addr;
  assign bus.q_count  = r_count;
  assign bus.q_pc     = r_q_pc;
  assign bus.q_byte0  = w_bytes[0];
  assign bus.q_byte1  = w_bytes[1];
  assign bus.q_byte2  = w_bytes[2];

`ifdef INST_PREFETCH_FLUSH_CNT_EN
  logic [15:0] r_flush_bytes;
  logic [16:0] w_flush_sum;
  logic        w_discard;

  // Flushed queue bytes plus any ack whose byte is thrown away.
  always_comb begin
    w_discard   = w_ack && (bus.redirect_valid || r_state == DROP);
    w_flush_sum = {1'b0, r_flush_bytes} + 17'(w_discard);
    if (bus.redirect_valid)
      w_flush_sum = w_flush_sum + 17'(r_count);
  end

  always_ff @(posedge clk) begin
    if (rst)
      r_flush_bytes <= '0;
    else
      r_flush_bytes <= w_flush_sum[16] ? 16'hFFFF : w_flush_sum[15:0];
  end

  assign flush_bytes = r_flush_bytes;
`endif

endmodule
